// File: rtl/dp_wb_lsu.sv
// dp_wb_lsu: writeback-stage load/store unit driving the data-memory bus and returning aligned load data
module dp_wb_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqW,
  input  logic        MemWriteW,
  input  logic [1:0]  MemSizeW,
  input  logic        MemUnsignedW,
  input  logic        FlushW,
  input  logic [4:0]  A3_W,
  input  logic [31:0] ALUResultW,
  input  logic [31:0] RD2_W,
  output logic        StallW,
  output logic        LoadValidW,
  output logic [31:0] LoadDataW,
  output logic [4:0]  LoadRdW,
  output logic        MisalignW,
  output logic        BusErrW,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  logic [1:0]  r_state;
  logic [1:0]  r_off;
  logic        r_byte;
  logic        r_half;
  logic        r_uns;
  logic        r_kill;
  logic [4:0]  r_rd;
  logic        w_byte;
  logic        w_half;
  logic        w_mis;
  logic        w_kill;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_sh;
  logic [31:0] w_ldata;
  always_comb begin
    w_byte  = MemSizeW == 2'b00;
    w_half  = MemSizeW == 2'b01;
    w_mis   = w_half ? ALUResultW[0] : (!w_byte && |ALUResultW[1:0]);
    w_be    = w_byte ? 4'b0001 << ALUResultW[1:0] : w_half ? 4'b0011 << ALUResultW[1:0] : 4'b1111;
    w_wdata = w_byte ? {4{RD2_W[7:0]}} : w_half ? {2{RD2_W[15:0]}} : RD2_W;
    w_sh    = mem_rdata >> {r_off, 3'b000};
    w_ldata = r_byte ? {{24{!r_uns && w_sh[7]}}, w_sh[7:0]} :
              r_half ? {{16{!r_uns && w_sh[15]}}, w_sh[15:0]} : w_sh;
    // a flush arriving in the completing cycle must still suppress the pulse
    w_kill  = r_kill || FlushW;
    StallW  = (r_state == S_IDLE && MemReqW && !FlushW) || r_state == S_REQ || r_state == S_WAIT;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_off      <= '0;
      r_byte     <= 1'b0;
      r_half     <= 1'b0;
      r_uns      <= 1'b0;
      r_kill     <= 1'b0;
      r_rd       <= '0;
      LoadValidW <= 1'b0;
      LoadDataW  <= '0;
      LoadRdW    <= '0;
      MisalignW  <= 1'b0;
      BusErrW    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      LoadValidW <= 1'b0;
      MisalignW  <= 1'b0;
      BusErrW    <= 1'b0;
      case (r_state)
        S_IDLE: if (MemReqW && !FlushW) begin
          r_off     <= ALUResultW[1:0];
          r_byte    <= w_byte;
          r_half    <= w_half;
          r_uns     <= MemUnsignedW;
          r_rd      <= A3_W;
          r_kill    <= 1'b0;
          mem_we    <= MemWriteW;
          mem_addr  <= {ALUResultW[31:2], 2'b00};
          mem_be    <= MemWriteW ? w_be : 4'b1111;
          mem_wdata <= w_wdata;
          r_state   <= w_mis ? S_DONE : S_REQ;
          mem_req   <= !w_mis;
          MisalignW <= w_mis;
        end
        S_REQ: begin
          r_kill <= w_kill;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            r_state <= mem_we ? S_DONE : S_WAIT;
            BusErrW <= mem_we && mem_err && !w_kill;
          end
        end
        S_WAIT: begin
          r_kill <= w_kill;
          if (mem_rvalid) begin
            r_state    <= S_DONE;
            BusErrW    <= mem_err && !w_kill;
            LoadValidW <= !mem_err && !w_kill;
            if (!mem_err && !w_kill) begin
              LoadDataW <= w_ldata;
              LoadRdW   <= r_rd;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_kill  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dp_wb_lsu.sv
// tb_dp_wb_lsu: directed scenarios for the writeback load/store unit with a reactive bus model
module tb_dp_wb_lsu;
  logic        clk = 0;
  logic        reset = 0;
  logic        MemReqW = 0;
  logic        MemWriteW = 0;
  logic [1:0]  MemSizeW = 0;
  logic        MemUnsignedW = 0;
  logic        FlushW = 0;
  logic [4:0]  A3_W = 0;
  logic [31:0] ALUResultW = 0;
  logic [31:0] RD2_W = 0;
  logic        StallW;
  logic        LoadValidW;
  logic [31:0] LoadDataW;
  logic [4:0]  LoadRdW;
  logic        MisalignW;
  logic        BusErrW;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 0;
  logic        mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;
  logic        mem_err = 0;
  int          checks = 0;
  int          failures = 0;
  int          stalls;
  int          reqs;
  logic [31:0] a_addr;
  logic [31:0] a_wd;
  logic [3:0]  a_be;
  logic        a_we;

  dp_wb_lsu dut (
    .clk(clk), .reset(reset), .MemReqW(MemReqW), .MemWriteW(MemWriteW), .MemSizeW(MemSizeW),
    .MemUnsignedW(MemUnsignedW), .FlushW(FlushW), .A3_W(A3_W), .ALUResultW(ALUResultW),
    .RD2_W(RD2_W), .StallW(StallW), .LoadValidW(LoadValidW), .LoadDataW(LoadDataW),
    .LoadRdW(LoadRdW), .MisalignW(MisalignW), .BusErrW(BusErrW), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Presents one op in an IDLE cycle, answers the bus after gwait/rwait cycles, returns sampling the DONE cycle
  task automatic run_op(input logic we, input logic [1:0] sz, input logic uns, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input logic err, input int gwait, input int rwait, input int fl);
    int   gcnt;
    int   rcnt;
    logic pend;
    logic done;
    gcnt = 0; rcnt = 0; pend = 0; done = 0; stalls = 0; reqs = 0;
    a_addr = 0; a_wd = 0; a_be = 0; a_we = 0;
    @(negedge clk);
    MemReqW = 1; MemWriteW = we; MemSizeW = sz; MemUnsignedW = uns; A3_W = rd;
    ALUResultW = addr; RD2_W = wd; FlushW = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = 0;
    #1;
    if (StallW) stalls++;
    for (int c = 1; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mem_gnt && !we) begin pend = 1; rcnt = 0; end
      mem_gnt = mem_req && gcnt == gwait;
      if (mem_req) gcnt++;
      mem_rvalid = pend && rcnt == rwait;
      if (pend) rcnt++;
      if (mem_rvalid) pend = 0;
      mem_err = err && (we ? mem_gnt : mem_rvalid);
      mem_rdata = mem_rvalid ? rdata : 32'h0;
      FlushW = (c == fl);
      #1;
      if (mem_req) begin
        if (reqs == 0) begin a_addr = mem_addr; a_wd = mem_wdata; a_be = mem_be; a_we = mem_we; end
        reqs++;
      end
      if (StallW) stalls++; else done = 1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL timeout: op at %h never released StallW", addr);
    end
  endtask

  task automatic idle_cycle;
    @(negedge clk);
    MemReqW = 0; FlushW = 0; mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = 0;
    #1;
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (StallW !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", StallW); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    checks++; if ({LoadValidW, MisalignW, BusErrW} !== 3'b000) begin failures++; $display("FAIL reset_pulses: got %b expected 000", {LoadValidW, MisalignW, BusErrW}); end
    checks++; if ({mem_addr, mem_be, mem_wdata, LoadDataW} !== 100'h0) begin failures++; $display("FAIL reset_data: addr %h be %h wd %h ld %h expected 0", mem_addr, mem_be, mem_wdata, LoadDataW); end
    reset = 1;
  endtask

  task automatic test_load_word;
    run_op(0, 2'b10, 0, 5'd5, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, -1);
    checks++; if (a_addr !== 32'h100) begin failures++; $display("FAIL lw_addr: got %h expected 00000100", a_addr); end
    checks++; if (a_be !== 4'b1111 || a_we !== 1'b0) begin failures++; $display("FAIL lw_be_we: got %b/%b expected 1111/0", a_be, a_we); end
    checks++; if (stalls !== 3) begin failures++; $display("FAIL lw_stalls: got %0d expected 3", stalls); end
    checks++; if (LoadValidW !== 1'b1) begin failures++; $display("FAIL lw_valid: got %b expected 1", LoadValidW); end
    checks++; if (LoadDataW !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data: got %h expected deadbeef", LoadDataW); end
    checks++; if (LoadRdW !== 5'd5) begin failures++; $display("FAIL lw_rd: got %0d expected 5", LoadRdW); end
    idle_cycle();
    checks++; if (LoadValidW !== 1'b0 || StallW !== 1'b0) begin failures++; $display("FAIL lw_after: valid %b stall %b expected 0 0", LoadValidW, StallW); end
  endtask

  task automatic test_load_extend;
    run_op(0, 2'b00, 0, 5'd7, 32'h103, 0, 32'h80FF0000, 0, 0, 0, -1);
    checks++; if (LoadDataW !== 32'hFFFFFF80 || LoadValidW !== 1'b1) begin failures++; $display("FAIL lb: got %h/%b expected ffffff80/1", LoadDataW, LoadValidW); end
    idle_cycle();
    run_op(0, 2'b00, 1, 5'd8, 32'h103, 0, 32'h80FF0000, 0, 0, 0, -1);
    checks++; if (LoadDataW !== 32'h00000080 || LoadRdW !== 5'd8) begin failures++; $display("FAIL lbu: got %h rd %0d expected 00000080 rd 8", LoadDataW, LoadRdW); end
    idle_cycle();
    run_op(0, 2'b01, 0, 5'd9, 32'h202, 0, 32'h80010000, 0, 1, 1, -1);
    checks++; if (LoadDataW !== 32'hFFFF8001) begin failures++; $display("FAIL lh: got %h expected ffff8001", LoadDataW); end
    checks++; if (stalls !== 5 || a_addr !== 32'h200) begin failures++; $display("FAIL lh_wait: stalls %0d addr %h expected 5 00000200", stalls, a_addr); end
    idle_cycle();
    run_op(0, 2'b01, 1, 5'd9, 32'h202, 0, 32'h80010000, 0, 0, 0, -1);
    checks++; if (LoadDataW !== 32'h00008001) begin failures++; $display("FAIL lhu: got %h expected 00008001", LoadDataW); end
    idle_cycle();
  endtask

  task automatic test_store;
    run_op(1, 2'b01, 0, 5'd0, 32'h102, 32'h1234ABCD, 0, 0, 2, 0, -1);
    checks++; if (a_be !== 4'b1100 || a_we !== 1'b1) begin failures++; $display("FAIL sh_be: got %b/%b expected 1100/1", a_be, a_we); end
    checks++; if (a_wd !== 32'hABCDABCD || a_addr !== 32'h100) begin failures++; $display("FAIL sh_wdata: got %h @%h expected abcdabcd @00000100", a_wd, a_addr); end
    checks++; if (reqs !== 3 || stalls !== 4) begin failures++; $display("FAIL sh_timing: req %0d stall %0d expected 3 4", reqs, stalls); end
    checks++; if ({LoadValidW, MisalignW, BusErrW} !== 3'b000) begin failures++; $display("FAIL sh_pulses: got %b expected 000", {LoadValidW, MisalignW, BusErrW}); end
    idle_cycle();
    run_op(1, 2'b00, 0, 5'd0, 32'h301, 32'h000000A5, 0, 0, 0, 0, -1);
    checks++; if (a_be !== 4'b0010 || a_wd !== 32'hA5A5A5A5 || stalls !== 2) begin failures++; $display("FAIL sb: be %b wd %h stalls %0d expected 0010 a5a5a5a5 2", a_be, a_wd, stalls); end
    idle_cycle();
    run_op(1, 2'b10, 0, 5'd0, 32'h404, 32'h11223344, 0, 1, 0, 0, -1);
    checks++; if (a_be !== 4'b1111 || a_wd !== 32'h11223344) begin failures++; $display("FAIL sw: be %b wd %h expected 1111 11223344", a_be, a_wd); end
    checks++; if (BusErrW !== 1'b1 || LoadValidW !== 1'b0) begin failures++; $display("FAIL sw_err: err %b valid %b expected 1 0", BusErrW, LoadValidW); end
    idle_cycle();
  endtask

  task automatic test_misalign;
    run_op(0, 2'b10, 0, 5'd3, 32'h101, 0, 0, 0, 0, 0, -1);
    checks++; if (MisalignW !== 1'b1 || LoadValidW !== 1'b0) begin failures++; $display("FAIL mis_lw: mis %b valid %b expected 1 0", MisalignW, LoadValidW); end
    checks++; if (stalls !== 1 || reqs !== 0) begin failures++; $display("FAIL mis_lw_timing: stall %0d req %0d expected 1 0", stalls, reqs); end
    idle_cycle();
    checks++; if (MisalignW !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL mis_after: mis %b req %b expected 0 0", MisalignW, mem_req); end
    run_op(0, 2'b11, 0, 5'd3, 32'h106, 0, 0, 0, 0, 0, -1);
    checks++; if (MisalignW !== 1'b1 || reqs !== 0) begin failures++; $display("FAIL mis_size3: mis %b req %0d expected 1 0", MisalignW, reqs); end
    idle_cycle();
    run_op(1, 2'b01, 0, 5'd0, 32'h203, 32'h5555, 0, 0, 0, 0, -1);
    checks++; if (MisalignW !== 1'b1 || reqs !== 0) begin failures++; $display("FAIL mis_sh: mis %b req %0d expected 1 0", MisalignW, reqs); end
    idle_cycle();
  endtask

  task automatic test_flush_and_error;
    run_op(0, 2'b10, 0, 5'd4, 32'h500, 0, 32'hCAFEF00D, 0, 0, 2, 2);
    checks++; if (LoadValidW !== 1'b0 || BusErrW !== 1'b0) begin failures++; $display("FAIL flush_pulse: valid %b err %b expected 0 0", LoadValidW, BusErrW); end
    checks++; if (stalls !== 5) begin failures++; $display("FAIL flush_stalls: got %0d expected 5", stalls); end
    idle_cycle();
    checks++; if (StallW !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL flush_idle: stall %b req %b expected 0 0", StallW, mem_req); end
    run_op(0, 2'b10, 0, 5'd6, 32'h600, 0, 32'h12345678, 1, 0, 0, -1);
    checks++; if (BusErrW !== 1'b1 || LoadValidW !== 1'b0) begin failures++; $display("FAIL lw_err: err %b valid %b expected 1 0", BusErrW, LoadValidW); end
    idle_cycle();
    checks++; if (BusErrW !== 1'b0) begin failures++; $display("FAIL lw_err_pulse: got %b expected 0", BusErrW); end
  endtask

  task automatic test_back_to_back;
    run_op(0, 2'b10, 0, 5'd10, 32'h700, 0, 32'hAAAA5555, 0, 0, 0, -1);
    run_op(0, 2'b00, 1, 5'd11, 32'h702, 0, 32'h00C30000, 0, 0, 0, -1);
    checks++; if (LoadDataW !== 32'h000000C3 || LoadRdW !== 5'd11) begin failures++; $display("FAIL b2b_data: got %h rd %0d expected 000000c3 rd 11", LoadDataW, LoadRdW); end
    checks++; if (stalls !== 3 || a_addr !== 32'h700) begin failures++; $display("FAIL b2b_timing: stalls %0d addr %h expected 3 00000700", stalls, a_addr); end
    idle_cycle();
  endtask

  task automatic test_reset_in_req;
    @(negedge clk);
    MemReqW = 1; MemWriteW = 0; MemSizeW = 2'b10; MemUnsignedW = 0; A3_W = 5'd12;
    ALUResultW = 32'h800; RD2_W = 32'hFFFFFFFF; mem_gnt = 0; mem_rvalid = 0;
    @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h800) begin failures++; $display("FAIL rq_req: req %b addr %h expected 1 00000800", mem_req, mem_addr); end
    reset = 0; MemReqW = 0;
    @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b0 || StallW !== 1'b0) begin failures++; $display("FAIL rq_reset: req %b stall %b expected 0 0", mem_req, StallW); end
    checks++; if ({mem_addr, mem_be, mem_we, LoadRdW} !== 42'h0) begin failures++; $display("FAIL rq_outputs: addr %h be %b we %b rd %0d expected 0", mem_addr, mem_be, mem_we, LoadRdW); end
    reset = 1;
    run_op(0, 2'b10, 0, 5'd13, 32'h804, 0, 32'h0BADF00D, 0, 0, 0, -1);
    checks++; if (LoadValidW !== 1'b1 || LoadDataW !== 32'h0BADF00D || LoadRdW !== 5'd13) begin failures++; $display("FAIL rq_after: valid %b data %h rd %0d expected 1 0badf00d 13", LoadValidW, LoadDataW, LoadRdW); end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_extend();
    test_store();
    test_misalign();
    test_flush_and_error();
    test_back_to_back();
    test_reset_in_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
